// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared opcodes, state encoding and line bundle for the sequencer
package seq_pkg;

  localparam int CNT_W_DEFAULT = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVI = 4'h1;
  localparam logic [3:0] OP_MOVA = 4'h2;
  localparam logic [3:0] OP_MOVB = 4'h3;
  localparam logic [3:0] OP_MOVC = 4'h4;
  localparam logic [3:0] OP_MOVD = 4'h5;
  localparam logic [3:0] OP_ADD  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JG   = 4'h9;
  localparam logic [3:0] OP_IN   = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_PUSH = 4'hC;
  localparam logic [3:0] OP_POP  = 4'hD;
  localparam logic [3:0] OP_NOP2 = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  typedef struct packed {
    logic mova;
    logic movb;
    logic movc;
    logic movd;
    logic add;
    logic sub;
    logic jmp;
    logic jg;
    logic in1;
    logic out1;
    logic movi;
    logic push;
    logic pop;
    logic halt;
  } op_lines_t;

endpackage

// File: rtl/op_decode.sv
// rtl/op_decode.sv - combinational 4-bit opcode to one-hot instruction lines
module op_decode
  import seq_pkg::*;
(
  input  logic [3:0] op_i,
  output op_lines_t  lines_o
);

  // Both nop opcodes (0 and E) fall through to the all-zero default.
  always_comb begin
    lines_o = '0;
    case (op_i)
      OP_MOVI: lines_o.movi = 1'b1;
      OP_MOVA: lines_o.mova = 1'b1;
      OP_MOVB: lines_o.movb = 1'b1;
      OP_MOVC: lines_o.movc = 1'b1;
      OP_MOVD: lines_o.movd = 1'b1;
      OP_ADD:  lines_o.add  = 1'b1;
      OP_SUB:  lines_o.sub  = 1'b1;
      OP_JMP:  lines_o.jmp  = 1'b1;
      OP_JG:   lines_o.jg   = 1'b1;
      OP_IN:   lines_o.in1  = 1'b1;
      OP_OUT:  lines_o.out1 = 1'b1;
      OP_PUSH: lines_o.push = 1'b1;
      OP_POP:  lines_o.pop  = 1'b1;
      OP_HALT: lines_o.halt = 1'b1;
      default: lines_o = '0;
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - fetch/execute sequencer with run/step control, I/O wait states
// and a retired-instruction counter
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [7:0]       ir,
  input  logic             in_vld,
  input  logic             out_rdy,
  output logic             sm,
  output logic             mova,
  output logic             movb,
  output logic             movc,
  output logic             movd,
  output logic             add,
  output logic             sub,
  output logic             jmp,
  output logic             jg,
  output logic             in1,
  output logic             out1,
  output logic             movi,
  output logic             push,
  output logic             pop,
  output logic             halt,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] icount
);

  state_t           state_q, state_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] icount_q, icount_d;

  op_lines_t dec;
  logic      in_exec;
  logic      io_wait;
  logic      done;
  logic      ir_operand_unused;

  op_decode u_dec (
    .op_i    (ir[7:4]),
    .lines_o (dec)
  );

  assign ir_operand_unused = ^ir[3:0];

  assign in_exec = (state_q == ST_EXEC);
  assign io_wait = (dec.in1 && !in_vld) || (dec.out1 && !out_rdy);
  assign done    = in_exec && !io_wait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      step_q   <= 1'b0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      icount_q <= icount_d;
    end
  end

  // run outranks step in IDLE; completion decides between FETCH, IDLE and HALTED.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    icount_d = icount_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
          step_d  = 1'b0;
        end else if (step) begin
          state_d = ST_FETCH;
          step_d  = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (done) begin
          icount_d = icount_q + CNT_W'(1);
          if (dec.halt) begin
            state_d = ST_HALTED;
          end else if (run && !step_q) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
            step_d  = 1'b0;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // sm stays high outside FETCH so ir_ld/pc_in/ram_re stay quiet while parked.
  always_comb begin
    sm     = (state_q != ST_FETCH);
    state  = state_q;
    icount = icount_q;
    mova   = in_exec && dec.mova;
    movb   = in_exec && dec.movb;
    movc   = in_exec && dec.movc;
    movd   = in_exec && dec.movd;
    add    = in_exec && dec.add;
    sub    = in_exec && dec.sub;
    jmp    = in_exec && dec.jmp;
    jg     = in_exec && dec.jg;
    in1    = in_exec && dec.in1 && in_vld;
    out1   = in_exec && dec.out1 && out_rdy;
    movi   = in_exec && dec.movi;
    push   = in_exec && dec.push;
    pop    = in_exec && dec.pop;
    halt   = (in_exec && dec.halt) || (state_q == ST_HALTED);
  end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Fetch/execute sequencer for the 8-bit machine. It owns the `sm` phase bit and turns the registered instruction byte into the one-hot instruction lines (`mova` … `pop`, `halt`) that the control-signal decoder consumes. It also adds:
- run/single-step control;
- wait-state handshakes for `in`/`out`;
- a retired-instruction counter.

It sits between the IR register and the control-signal decoder.

## Interface
- `CNT_W`, 16, width of retired-instruction counter
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `run`  in  1  level; 1 = free-running execution
- `step`  in  1  one-cycle pulse; executes one instruction when idle
- `ir`  in  8  instruction register contents; opcode = `ir[7:4]`
- `in_vld`  in  1  input port has data
- `out_rdy`  in  1  output port can accept data
- `sm`  out  1  phase: 0 = fetch, 1 = execute/held
- `mova`,`movb`,`movc`,`movd`,`add`,`sub`,`jmp`,`jg`,`in1`,`out1`,`movi`,`push`,`pop`,`halt`  out  1 each  one-hot instruction lines, valid only in EXEC
- `state`  out  2  current state (debug)
- `icount`  out  CNT_W  retired instructions

## Operation
- Opcodes (`ir[7:4]`):
  - 1 `movi`, 2 `mova`, 3 `movb`, 4 `movc`, 5 `movd`
  - 6 `add`, 7 `sub`, 8 `jmp`, 9 `jg`
  - A `in1`, B `out1`, C `push`, D `pop`, F `halt`
  - 0 and E are nop: no line asserted; they still retire.
- States: IDLE=0, FETCH=1, EXEC=2, HALTED=3.
- `sm` is 0 only in FETCH. It is 1 in EXEC, IDLE and HALTED, so the downstream `ir_ld`/`pc_in`/`ram_re` do not fire while idle.
- Instruction lines are all 0 outside EXEC.
- IDLE:
  - `run`=1 → FETCH.
  - Else `step`=1 → FETCH with a single-step flag set.
  - `run` and `step` together: `run` wins and the step flag is cleared.
- FETCH → EXEC unconditionally, 1 cycle.
- EXEC completion:
  - Opcodes other than A/B complete in 1 cycle.
  - `in1` completes in the cycle `in_vld`=1. While waiting, stay in EXEC with `in1`=0.
  - `out1` completes in the cycle `out_rdy`=1. While waiting, stay in EXEC with `out1`=0.
  - `in1`/`out1` therefore assert for exactly one cycle per instruction.
- On EXEC completion:
  - `icount` += 1, wrapping modulo 2^CNT_W.
  - Opcode F → HALTED. `halt`=1 during that EXEC cycle and held at 1 in HALTED.
  - Otherwise, if `run`=1 and the step flag is clear → FETCH.
  - Otherwise → IDLE, and the step flag clears.
- `run` dropping mid-instruction: the current instruction still completes, then the block goes to IDLE.
- HALTED: exited only by `rst`. `run` and `step` are ignored.
- `step` arriving while not in IDLE is ignored (not queued).

## Timing
- Minimum 2 cycles per instruction (FETCH + EXEC). `in`/`out` take 2 + wait cycles.
- Instruction lines are combinational from the registered state and `ir`; `in_vld`/`out_rdy` gate them combinationally within the cycle.
- IR is loaded at the FETCH→EXEC edge by the downstream `ir_ld`.
- `rst` asserted (asynchronously, at any time, including mid-wait):
  - `state`=IDLE, step flag=0, `icount`=0, `sm`=1, all instruction lines 0.
  - First FETCH occurs on the first rising edge after `rst` falls with `run`=1.

## Structure
- Package `seq_pkg` holds:
  - opcode constants `OP_MOVI`…`OP_HALT`;
  - state encoding `ST_IDLE`/`ST_FETCH`/`ST_EXEC`/`ST_HALTED`;
  - `CNT_W` default.
- Sub-module `op_decode`: purely combinational 4-bit opcode → 14 one-hot lines, no enable input. `seq_ctrl` gates its outputs with EXEC and the I/O handshakes.
- The FSM, step flag and counter live in `seq_ctrl`.

## Test plan
- Reset, `run`=1, program `ir` = 0x61, 0x71, 0xF0 → `sm` toggles 0,1,0,1,0,1.
  - `add`, `sub`, `halt` are each high for one EXEC cycle.
  - End state: HALTED, `icount`=3, `sm`=1.
- `run`=0, `step` pulse, `ir`=0x24 → exactly one FETCH+EXEC with `mova`=1, then IDLE. `icount`=1. No further FETCH until the next `step`.
- `ir`=0xA4 with `in_vld` low for 5 cycles then high → EXEC lasts 6 cycles and `in1` is high only in the last one. The same pattern applies to 0xB0 with `out_rdy`.
- `run` and `step` both high in IDLE → continuous execution. Dropping `run` during EXEC of 0x90 → `jg` completes, then IDLE.
- `CNT_W`=4: run 17 nops (0x00) → `icount` wraps to 1. No instruction line ever asserts.
- Assert `rst` mid-wait on 0xA0 → outputs immediately: `state`=0, `sm`=1, `icount`=0, `in1`=0. No `in1` pulse afterwards even if `in_vld`=1.
